// File: rtl/axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_master_bridge
// Brief   : Single-outstanding command/response to AXI4-Lite master bridge.
// Rev     : 1.0  initial release
// ============================================================================
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_wdata,
    input  logic [3:0]            i_cmd_wstrb,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_write,
    output logic [1:0]            o_rsp_resp,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    output logic [31:0]           o_wdata,
    output logic [3:0]            o_wstrb,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    input  logic [1:0]            i_bresp,
    output logic                  o_bready,
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    input  logic [31:0]           i_rdata,
    input  logic [1:0]            i_rresp,
    output logic                  o_rready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    state_t                state_q;
    logic                  cmd_ready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic [1:0]            rsp_resp_q;
    logic [31:0]           rsp_rdata_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    // A channel counts as done once its VALID is already low or handshakes now.
    logic w_aw_done;
    logic w_w_done;

    assign w_aw_done = !awvalid_q || i_awready;
    assign w_w_done  = !wvalid_q  || i_wready;

    always_ff @(posedge i_axi_clk or posedge i_axi_rst) begin
        if (i_axi_rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= 32'd0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (i_cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        rsp_write_q <= i_cmd_write;
                        if (i_cmd_write) begin
                            awaddr_q  <= i_cmd_addr;
                            wdata_q   <= i_cmd_wdata;
                            wstrb_q   <= i_cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WRITE;
                        end else begin
                            araddr_q  <= i_cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    if (awvalid_q && i_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && i_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (i_bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= i_bresp;
                        rsp_rdata_q <= 32'd0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RADDR: begin
                    if (i_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (i_rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= i_rdata;
                        rsp_resp_q  <= i_rresp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_write = rsp_write_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_awvalid   = awvalid_q;
    assign o_awaddr    = awaddr_q;
    assign o_wvalid    = wvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_bready    = bready_q;
    assign o_arvalid   = arvalid_q;
    assign o_araddr    = araddr_q;
    assign o_rready    = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_master_bridge
// Brief   : Directed self-checking bench with slave model and scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axi_lite_master_bridge;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid, i_cmd_write, i_rsp_ready;
    logic [31:0] i_cmd_addr, i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_write;
    logic [1:0]  o_rsp_resp;
    logic [31:0] o_rsp_rdata;
    logic        o_awvalid, i_awready, o_wvalid, i_wready;
    logic [31:0] o_awaddr, o_wdata, o_araddr;
    logic [3:0]  o_wstrb;
    logic        i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
    logic [1:0]  i_bresp, i_rresp;
    logic [31:0] i_rdata;

    axi_lite_master_bridge #(.ADDR_WIDTH(32)) dut (
        .i_axi_clk(clk), .i_axi_rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_resp(o_rsp_resp), .o_rsp_rdata(o_rsp_rdata),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp), .o_rready(o_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Slave behaviour knobs
    int aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  bresp_v, rresp_v;
    logic [31:0] rdata_v;
    bit          stale_b;

    // Per-transaction observations
    int cyc, hs_cyc, last_lat, aw_hs_cyc, w_hs_cyc, b_hs;
    int aw_cycles, w_cycles, ar_cycles, r_cycles, rsp_cycles;
    bit in_flight, lat_pend;
    logic        last_write;
    logic [1:0]  last_resp;
    logic [31:0] last_rdata;

    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rsv, p_rsr, p_rsw;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rsdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_rsresp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Slave model, protocol monitor and scoreboard, all evaluated at negedge.
    initial begin : monitor
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_bresp = 0;
                i_rvalid = 0; i_rdata = 0; i_rresp = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_rsv = 0;
                p_awr = 0; p_wr = 0; p_arr = 0; p_rsr = 0;
                exp_q.delete();
                in_flight = 0;
                lat_pend  = 0;
            end else begin
                if (p_awv && !p_awr)
                    chk("aw_hold", {o_awvalid, o_awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wr)
                    chk("w_hold", {o_wvalid, o_wstrb, o_wdata}, {1'b1, p_wstrb, p_wdata});
                if (p_arv && !p_arr)
                    chk("ar_hold", {o_arvalid, o_araddr}, {1'b1, p_araddr});
                if (p_rsv && !p_rsr)
                    chk("rsp_hold", {o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_rdata},
                        {1'b1, p_rsw, p_rsresp, p_rsdata});

                if (o_awvalid) begin i_awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin i_awready = 0; aw_cnt = 0; end
                if (o_wvalid) begin i_wready = (w_cnt >= w_dly); w_cnt++; end
                else begin i_wready = 0; w_cnt = 0; end
                if (o_arvalid) begin i_arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin i_arready = 0; ar_cnt = 0; end
                if (stale_b) begin
                    i_bvalid = 1; i_bresp = 2'b11;
                end else if (o_bready) begin
                    i_bvalid = (b_cnt >= b_dly); i_bresp = i_bvalid ? bresp_v : 2'b00; b_cnt++;
                end else begin
                    i_bvalid = 0; i_bresp = 0; b_cnt = 0;
                end
                if (o_rready) begin
                    i_rvalid = (r_cnt >= r_dly);
                    i_rdata  = i_rvalid ? rdata_v : 32'd0;
                    i_rresp  = i_rvalid ? rresp_v : 2'b00;
                    r_cnt++;
                end else begin
                    i_rvalid = 0; i_rdata = 0; i_rresp = 0; r_cnt = 0;
                end

                if (o_awvalid) aw_cycles++;
                if (o_wvalid)  w_cycles++;
                if (o_arvalid) ar_cycles++;
                if (o_rready)  r_cycles++;
                if (o_rsp_valid) rsp_cycles++;
                if (o_awvalid && i_awready) begin
                    aw_hs_cyc = cyc;
                    if (exp_q.size() > 0) chk("awaddr", o_awaddr, exp_q[0].addr);
                end
                if (o_wvalid && i_wready) begin
                    w_hs_cyc = cyc;
                    if (exp_q.size() > 0) chk("wdata_wstrb", {o_wstrb, o_wdata}, {exp_q[0].wstrb, exp_q[0].wdata});
                end
                if (o_arvalid && i_arready && exp_q.size() > 0)
                    chk("araddr", o_araddr, exp_q[0].addr);
                if (o_bready && i_bvalid) b_hs++;

                if (in_flight) chk("cmd_ready_busy", o_cmd_ready, 1'b0);
                if (!in_flight && lat_pend && o_cmd_ready) begin
                    last_lat = cyc - hs_cyc;
                    lat_pend = 0;
                end
                if (i_cmd_valid && o_cmd_ready) begin
                    in_flight = 1; lat_pend = 1; hs_cyc = cyc;
                end
                if (o_rsp_valid && i_rsp_ready) begin
                    last_write = o_rsp_write; last_resp = o_rsp_resp; last_rdata = o_rsp_rdata;
                    in_flight  = 0;
                    if (exp_q.size() == 0) begin
                        chk("rsp_expected", 1'b0, 1'b1);
                    end else begin
                        chk("rsp_fields", {o_rsp_write, o_rsp_resp, o_rsp_rdata},
                            {exp_q[0].wr, exp_q[0].resp, exp_q[0].rdata});
                        void'(exp_q.pop_front());
                    end
                end

                p_awv = o_awvalid; p_awr = i_awready; p_awaddr = o_awaddr;
                p_wv  = o_wvalid;  p_wr  = i_wready;  p_wdata  = o_wdata; p_wstrb = o_wstrb;
                p_arv = o_arvalid; p_arr = i_arready; p_araddr = o_araddr;
                p_rsv = o_rsp_valid; p_rsr = i_rsp_ready; p_rsw = o_rsp_write;
                p_rsresp = o_rsp_resp; p_rsdata = o_rsp_rdata;
            end
        end
    end

    task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r);
        aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    task automatic clr();
        aw_cycles = 0; w_cycles = 0; ar_cycles = 0; r_cycles = 0; rsp_cycles = 0;
        b_hs = 0; aw_hs_cyc = -1; w_hs_cyc = -2; last_lat = -1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [1:0] resp, input logic [31:0] rd);
        txn_t t;
        bit   ok;
        t.wr = wr; t.resp = resp; t.rdata = rd; t.addr = addr; t.wdata = wd; t.wstrb = ws;
        exp_q.push_back(t);
        @(posedge clk); #2;
        i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = ws;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_cmd_ready) begin ok = 1; break; end
        end
        chk("cmd_accept", ok, 1'b1);
        @(posedge clk); #2;
        i_cmd_valid = 0;
    endtask

    task automatic wait_done(input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (o_cmd_ready && exp_q.size() == 0) begin ok = 1; break; end
        end
        chk("txn_complete", ok, 1'b1);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        rst = 1; stale_b = 0;
        i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_cmd_wstrb = 0;
        i_rsp_ready = 0;
        bresp_v = 0; rresp_v = 0; rdata_v = 0;
        set_slave(0, 0, 0, 0, 0);
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", o_cmd_ready, 1'b0);
        chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid}, 6'd0);
        chk("rst_addr", {o_awaddr, o_araddr}, 64'd0);
        chk("rst_wdata", {o_wstrb, o_wdata}, 36'd0);
        chk("rst_rsp", {o_rsp_write, o_rsp_resp, o_rsp_rdata}, 35'd0);
        @(posedge clk); #2;
        rst = 0;
        i_rsp_ready = 1;
        @(negedge clk);
        chk("cmd_ready_pre_edge", o_cmd_ready, 1'b0);
        @(negedge clk);
        chk("cmd_ready_after_rst", o_cmd_ready, 1'b1);

        // Zero-wait write
        clr();
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'd0);
        wait_done(40);
        chk("t1_aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);
        chk("t1_b_handshakes", b_hs, 1);
        chk("t1_latency", last_lat, 4);
        chk("t1_rsp", {last_write, last_resp, last_rdata}, {1'b1, 2'b00, 32'd0});

        // Read with 3 RVALID wait cycles
        set_slave(0, 0, 0, 0, 3);
        rdata_v = 32'h1234_5678; rresp_v = 2'b00;
        clr();
        issue(1'b0, 32'h0000_0004, 32'd0, 4'd0, 2'b00, 32'h1234_5678);
        wait_done(40);
        chk("t2_arvalid_cycles", ar_cycles, 1);
        chk("t2_rready_cycles", r_cycles, 4);
        chk("t2_rdata", last_rdata, 32'h1234_5678);
        chk("t2_write_flag", last_write, 1'b0);

        // W lags AW by 5 cycles
        set_slave(0, 5, 0, 0, 0);
        clr();
        issue(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b0101, 2'b00, 32'd0);
        wait_done(60);
        chk("t3_awvalid_cycles", aw_cycles, 1);
        chk("t3_wvalid_cycles", w_cycles, 6);
        chk("t3_b_handshakes", b_hs, 1);

        // SLVERR read with response back-pressure
        set_slave(0, 0, 0, 0, 0);
        rdata_v = 32'h0BAD_0BAD; rresp_v = 2'b10;
        i_rsp_ready = 0;
        clr();
        issue(1'b0, 32'h0000_0044, 32'd0, 4'd0, 2'b10, 32'h0BAD_0BAD);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_rsp_valid) begin ok = 1; break; end
        end
        chk("t4_rsp_seen", ok, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        i_rsp_ready = 1;
        wait_done(20);
        chk("t4_rsp_valid_cycles", rsp_cycles, 5);
        chk("t4_resp", last_resp, 2'b10);

        // AW lags W, DECERR write response
        set_slave(2, 0, 0, 2, 0);
        bresp_v = 2'b11;
        clr();
        issue(1'b1, 32'h0000_0ABC, 32'h0102_0304, 4'b1000, 2'b11, 32'd0);
        wait_done(40);
        chk("t5_awvalid_cycles", aw_cycles, 3);
        chk("t5_wvalid_cycles", w_cycles, 1);
        chk("t5_resp", last_resp, 2'b11);

        // Reset while waiting for B, then a read with a stale BVALID present
        set_slave(0, 0, 0, 30, 0);
        bresp_v = 2'b00;
        clr();
        issue(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF, 2'b00, 32'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_bready) begin ok = 1; break; end
        end
        chk("t6_reach_wresp", ok, 1'b1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("t6_rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rsp_valid, o_cmd_ready}, 7'd0);
        chk("t6_rst_addr", {o_awaddr, o_araddr}, 64'd0);
        chk("t6_rst_wdata", {o_wstrb, o_wdata}, 36'd0);
        chk("t6_rst_rsp", {o_rsp_write, o_rsp_resp, o_rsp_rdata}, 35'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        stale_b = 1;
        set_slave(0, 0, 0, 0, 1);
        rdata_v = 32'hCAFE_F00D; rresp_v = 2'b00;
        clr();
        issue(1'b0, 32'h0000_0008, 32'd0, 4'd0, 2'b00, 32'hCAFE_F00D);
        wait_done(40);
        chk("t6_stale_b_ignored", b_hs, 0);
        chk("t6_read_rsp", {last_write, last_resp, last_rdata}, {1'b0, 2'b00, 32'hCAFE_F00D});
        stale_b = 0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
